// File: rtl/register_scoreboard_unit_if.sv
// register_scoreboard_unit_if
//   Groups the decode/issue/write-back signals of the register scoreboard
//   unit. The read ports are flattened: port i occupies
//   rd_addr[i*ADDR_W +: ADDR_W], rd_data[i*WIDTH +: WIDTH], rd_used[i],
//   and rd_busy[i].
//
//   master : pipeline side. It drives enable, reads, issue and write-back
//            requests, and receives read data, busy flags, stall and
//            busy_count.
//   slave  : register_scoreboard_unit side.
interface register_scoreboard_unit_if #(
    parameter int SIZE       = 32,
    parameter int WIDTH      = 32,
    parameter int READ_PORTS = 2
);
    localparam int ADDR_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                         enable;
    logic [READ_PORTS-1:0]        rd_used;
    logic [READ_PORTS*ADDR_W-1:0] rd_addr;
    logic [READ_PORTS*WIDTH-1:0]  rd_data;
    logic [READ_PORTS-1:0]        rd_busy;
    logic                         issue_valid;
    logic                         issue_has_rd;
    logic [ADDR_W-1:0]            issue_rd;
    logic                         stall;
    logic                         wb_valid;
    logic [ADDR_W-1:0]            wb_rd;
    logic [WIDTH-1:0]             wb_data;
    logic [ADDR_W:0]              busy_count;

    modport master (
        output enable, rd_used, rd_addr, issue_valid, issue_has_rd, issue_rd,
               wb_valid, wb_rd, wb_data,
        input  rd_data, rd_busy, stall, busy_count
    );

    modport slave (
        input  enable, rd_used, rd_addr, issue_valid, issue_has_rd, issue_rd,
               wb_valid, wb_rd, wb_data,
        output rd_data, rd_busy, stall, busy_count
    );
endinterface

// File: rtl/register_scoreboard_unit.sv
// register_scoreboard_unit
//   This module is an integer register file with a per-register busy bit,
//   which forms a scoreboard. An issuing instruction reserves its
//   destination, which sets the busy bit. A write-back stores the data and
//   clears the busy bit. Decode is stalled on RAW hazards, where a used
//   source is busy, and on WAW hazards, where the destination is busy. With
//   BYPASS=1, a write-back in the current cycle is forwarded to the read
//   ports and also releases hazards in that same cycle.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset. It clears all data, all busy
//            bits and the counter.
//   bus    : register_scoreboard_unit_if.slave. The bus carries enable, the
//            read ports (rd_used/rd_addr/rd_data/rd_busy), the issue port
//            (issue_valid/issue_has_rd/issue_rd/stall), the write-back port
//            (wb_valid/wb_rd/wb_data) and busy_count.
module register_scoreboard_unit #(
    parameter int SIZE       = 32,
    parameter int WIDTH      = 32,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    register_scoreboard_unit_if.slave bus
);
    localparam int ADDR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ADDR_W:0] SIZE_W = (ADDR_W + 1)'(SIZE);

    logic [WIDTH-1:0]  regs_reg [SIZE];
    logic [SIZE-1:0]   busy_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;

    logic wb_in_range;
    logic issue_in_range;
    logic wb_fire;
    logic issue_fire;
    logic issue_busy_eff;
    logic count_inc;
    logic count_dec;

    logic [READ_PORTS-1:0][WIDTH-1:0] rd_data_w;
    logic [READ_PORTS-1:0]            rd_busy_w;

    assign wb_in_range    = ({1'b0, bus.wb_rd} < SIZE_W);
    assign issue_in_range = ({1'b0, bus.issue_rd} < SIZE_W);

    assign wb_fire = bus.enable & bus.wb_valid
                   & ~((ZERO_REG != 0) && (bus.wb_rd == '0));

    // Read ports. A write-back in the current cycle to the same address
    // overrides the stored value and hides the busy bit.
    for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              valid_addr;
        logic              hit;

        assign addr       = bus.rd_addr[gi*ADDR_W +: ADDR_W];
        assign valid_addr = ({1'b0, addr} < SIZE_W)
                          & ~((ZERO_REG != 0) && (addr == '0));
        assign hit        = (BYPASS != 0) && wb_fire && (bus.wb_rd == addr);

        assign rd_data_w[gi] = hit        ? bus.wb_data :
                               valid_addr ? regs_reg[addr] : '0;
        assign rd_busy_w[gi] = ~hit & valid_addr & busy_reg[addr] & bus.rd_used[gi];
    end

    assign bus.rd_data = rd_data_w;
    assign bus.rd_busy = rd_busy_w;

    // WAW check. A destination that is being written back in this cycle
    // counts as free when bypassing is enabled. Register 0 is never set
    // busy, so it needs no special case here.
    assign issue_busy_eff = issue_in_range & busy_reg[bus.issue_rd]
                          & ~((BYPASS != 0) && wb_fire && (bus.wb_rd == bus.issue_rd));

    assign bus.stall = bus.issue_valid & ((|rd_busy_w) | (bus.issue_has_rd & issue_busy_eff));

    assign issue_fire = bus.enable & bus.issue_valid & ~bus.stall & bus.issue_has_rd
                      & ~((ZERO_REG != 0) && (bus.issue_rd == '0));

    // The counter tracks the popcount of busy_reg. When the issue and the
    // write-back target the same register, the issue wins. The write-back
    // therefore never decrements in that case, and the issue increments
    // only if the bit was clear.
    assign count_inc = issue_fire & issue_in_range & ~busy_reg[bus.issue_rd];
    assign count_dec = wb_fire & wb_in_range & busy_reg[bus.wb_rd]
                     & ~(issue_fire & issue_in_range & (bus.issue_rd == bus.wb_rd));

    always_comb begin
        count_next = count_reg;
        if (count_inc && !count_dec) begin
            count_next = count_reg + (ADDR_W + 1)'(1);
        end else if (count_dec && !count_inc) begin
            count_next = count_reg - (ADDR_W + 1)'(1);
        end
    end

    assign bus.busy_count = count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SIZE; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (wb_fire && wb_in_range) begin
                regs_reg[bus.wb_rd] <= bus.wb_data;
                busy_reg[bus.wb_rd] <= 1'b0;
            end
            // This assignment comes after the write-back clear, so the new
            // reservation wins when both target the same register.
            if (issue_fire && issue_in_range) begin
                busy_reg[bus.issue_rd] <= 1'b1;
            end
            count_reg <= count_next;
        end
    end
endmodule

// File: tb/tb_register_scoreboard_unit.sv
// tb_register_scoreboard_unit
//   This bench drives two instances from identical stimulus: dut_b with
//   BYPASS=1 and dut_n with BYPASS=0. Each instance has its own reference
//   model, made of plain arrays of register values and busy flags. The
//   bench runs directed hazard scenarios, then randomized traffic with
//   occasional asynchronous reset pulses.
module tb_register_scoreboard_unit;
    localparam int SIZE  = 32;
    localparam int WIDTH = 32;
    localparam int RP    = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              enable;
    logic [RP-1:0]     rd_used;
    logic [RP*AW-1:0]  rd_addr;
    logic              issue_valid;
    logic              issue_has_rd;
    logic [AW-1:0]     issue_rd;
    logic              wb_valid;
    logic [AW-1:0]     wb_rd;
    logic [WIDTH-1:0]  wb_data;

    register_scoreboard_unit_if #(.SIZE(SIZE), .WIDTH(WIDTH), .READ_PORTS(RP)) bus_b ();
    register_scoreboard_unit_if #(.SIZE(SIZE), .WIDTH(WIDTH), .READ_PORTS(RP)) bus_n ();

    assign bus_b.enable       = enable;
    assign bus_b.rd_used      = rd_used;
    assign bus_b.rd_addr      = rd_addr;
    assign bus_b.issue_valid  = issue_valid;
    assign bus_b.issue_has_rd = issue_has_rd;
    assign bus_b.issue_rd     = issue_rd;
    assign bus_b.wb_valid     = wb_valid;
    assign bus_b.wb_rd        = wb_rd;
    assign bus_b.wb_data      = wb_data;

    assign bus_n.enable       = enable;
    assign bus_n.rd_used      = rd_used;
    assign bus_n.rd_addr      = rd_addr;
    assign bus_n.issue_valid  = issue_valid;
    assign bus_n.issue_has_rd = issue_has_rd;
    assign bus_n.issue_rd     = issue_rd;
    assign bus_n.wb_valid     = wb_valid;
    assign bus_n.wb_rd        = wb_rd;
    assign bus_n.wb_data      = wb_data;

    register_scoreboard_unit #(.SIZE(SIZE), .WIDTH(WIDTH), .READ_PORTS(RP),
                               .BYPASS(1), .ZERO_REG(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    register_scoreboard_unit #(.SIZE(SIZE), .WIDTH(WIDTH), .READ_PORTS(RP),
                               .BYPASS(0), .ZERO_REG(1)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n.slave)
    );

    // Model index 0 stands for the BYPASS=1 instance. Index 1 stands for
    // the BYPASS=0 instance.
    logic [WIDTH-1:0] m_regs [2][SIZE];
    bit               m_busy [2][SIZE];

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < SIZE; r++) begin
                m_regs[m][r] = '0;
                m_busy[m][r] = 1'b0;
            end
        end
    endtask

    function automatic bit m_wb_fire();
        return enable && wb_valid && (wb_rd != 0);
    endfunction

    function automatic int port_addr(int p);
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        return int'(a);
    endfunction

    function automatic bit bypass_hit(int m, int a);
        return (m == 0) && m_wb_fire() && (int'(wb_rd) == a);
    endfunction

    function automatic logic [WIDTH-1:0] exp_rd_data(int m, int p);
        int a;
        a = port_addr(p);
        if (bypass_hit(m, a)) return wb_data;
        if (a == 0) return '0;
        return m_regs[m][a];
    endfunction

    function automatic bit exp_rd_busy(int m, int p);
        int a;
        a = port_addr(p);
        if (bypass_hit(m, a)) return 1'b0;
        return (a != 0) && m_busy[m][a] && rd_used[p];
    endfunction

    function automatic bit exp_stall(int m);
        bit raw;
        bit waw;
        raw = 1'b0;
        for (int p = 0; p < RP; p++) raw |= exp_rd_busy(m, p);
        waw = issue_has_rd && m_busy[m][issue_rd] && !bypass_hit(m, int'(issue_rd));
        return issue_valid && (raw || waw);
    endfunction

    function automatic int exp_count(int m);
        int n;
        n = 0;
        for (int r = 0; r < SIZE; r++) n += int'(m_busy[m][r]);
        return n;
    endfunction

    task automatic check_all(input string tag);
        for (int p = 0; p < RP; p++) begin
            check_eq($sformatf("%s.b.rd_data%0d", tag, p), 64'(bus_b.rd_data[p*WIDTH +: WIDTH]), 64'(exp_rd_data(0, p)));
            check_eq($sformatf("%s.n.rd_data%0d", tag, p), 64'(bus_n.rd_data[p*WIDTH +: WIDTH]), 64'(exp_rd_data(1, p)));
            check_eq($sformatf("%s.b.rd_busy%0d", tag, p), 64'(bus_b.rd_busy[p]), 64'(exp_rd_busy(0, p)));
            check_eq($sformatf("%s.n.rd_busy%0d", tag, p), 64'(bus_n.rd_busy[p]), 64'(exp_rd_busy(1, p)));
        end
        check_eq({tag, ".b.stall"}, 64'(bus_b.stall), 64'(exp_stall(0)));
        check_eq({tag, ".n.stall"}, 64'(bus_n.stall), 64'(exp_stall(1)));
        check_eq({tag, ".b.busy_count"}, 64'(bus_b.busy_count), 64'(exp_count(0)));
        check_eq({tag, ".n.busy_count"}, 64'(bus_n.busy_count), 64'(exp_count(1)));
    endtask

    // This task is called shortly after a negedge, once the inputs are
    // driven. It prints the transaction line and checks every output.
    task automatic settle(input string tag);
        #1;
        $display("[%0t] %s en=%0b wb=%0b x%0d=%h iss=%0b/%0b x%0d used=%b addr=%0d,%0d stall_b=%0b stall_n=%0b cnt_b=%0d cnt_n=%0d",
                 $time, tag, enable, wb_valid, wb_rd, wb_data, issue_valid, issue_has_rd, issue_rd,
                 rd_used, port_addr(0), port_addr(1), bus_b.stall, bus_n.stall,
                 bus_b.busy_count, bus_n.busy_count);
        check_all(tag);
    endtask

    // This task applies the pending rules to both models, then crosses the
    // posedge and the following negedge.
    task automatic advance();
        for (int m = 0; m < 2; m++) begin
            bit wf;
            bit isf;
            wf  = m_wb_fire();
            isf = enable && issue_valid && !exp_stall(m) && issue_has_rd && (issue_rd != 0);
            if (wf) begin
                m_regs[m][wb_rd] = wb_data;
                m_busy[m][wb_rd] = 1'b0;
            end
            if (isf) m_busy[m][issue_rd] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        enable       = 1'b1;
        rd_used      = '0;
        rd_addr      = '0;
        issue_valid  = 1'b0;
        issue_has_rd = 1'b0;
        issue_rd     = '0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
    endtask

    task automatic set_port(input int p, input int a, input bit used);
        rd_addr[p*AW +: AW] = AW'(a);
        rd_used[p]          = used;
    endtask

    task automatic do_issue(input int rd);
        issue_valid  = 1'b1;
        issue_has_rd = 1'b1;
        issue_rd     = AW'(rd);
    endtask

    task automatic do_wb(input int rd, input logic [WIDTH-1:0] d);
        wb_valid = 1'b1;
        wb_rd    = AW'(rd);
        wb_data  = d;
    endtask

    // The reset pulse is asserted and released inside the low clock phase.
    // Enable is held low, so the next posedge changes nothing.
    task automatic pulse_reset(input string tag);
        enable      = 1'b0;
        wb_valid    = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        check_eq({tag, ".b.busy_count_zero"}, 64'(bus_b.busy_count), 64'd0);
        check_eq({tag, ".b.stall_zero"}, 64'(bus_b.stall), 64'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b1;
    endtask

    initial begin
        int cnt_before;
        idle();
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        reset = 1'b1;
        @(negedge clk);

        // Scenario: a RAW hazard on x5 is resolved by write-back.
        idle(); do_issue(5);
        settle("raw.issue"); advance();
        idle(); set_port(0, 5, 1); issue_valid = 1'b1;
        settle("raw.wait");
        check_eq("raw.b.busy_const", 64'(bus_b.rd_busy[0]), 64'd1);
        check_eq("raw.n.stall_const", 64'(bus_n.stall), 64'd1);
        advance();
        do_wb(5, 32'hDEADBEEF);
        settle("raw.wb");
        check_eq("raw.b.bypass_data", 64'(bus_b.rd_data[WIDTH-1:0]), 64'hDEADBEEF);
        check_eq("raw.b.stall_released", 64'(bus_b.stall), 64'd0);
        check_eq("raw.n.stall_held", 64'(bus_n.stall), 64'd1);
        advance();
        wb_valid = 1'b0;
        settle("raw.after");
        check_eq("raw.n.data_next", 64'(bus_n.rd_data[WIDTH-1:0]), 64'hDEADBEEF);
        check_eq("raw.n.stall_clear", 64'(bus_n.stall), 64'd0);
        advance();

        // Scenario: register 0 is never written and never reserved.
        idle(); do_wb(0, 32'h1234); do_issue(0); set_port(0, 0, 1);
        cnt_before = exp_count(0);
        settle("zero");
        check_eq("zero.b.rd_data", 64'(bus_b.rd_data[WIDTH-1:0]), 64'd0);
        advance();
        idle(); set_port(0, 0, 1);
        settle("zero.after");
        check_eq("zero.b.count", 64'(bus_b.busy_count), 64'(cnt_before));
        check_eq("zero.n.rd_data", 64'(bus_n.rd_data[WIDTH-1:0]), 64'd0);
        advance();

        // Scenario: write-back and reservation of x7 in the same cycle.
        idle(); do_issue(7);
        settle("same.pre"); advance();
        idle(); do_wb(7, 32'hCAFE0007); do_issue(7);
        cnt_before = exp_count(0);
        settle("same.both"); advance();
        idle(); set_port(0, 7, 1);
        settle("same.after");
        check_eq("same.b.data", 64'(bus_b.rd_data[WIDTH-1:0]), 64'hCAFE0007);
        check_eq("same.b.busy", 64'(bus_b.rd_busy[0]), 64'd1);
        check_eq("same.b.count", 64'(bus_b.busy_count), 64'(cnt_before));
        advance();

        // Scenario: a WAW stall on x3, then a frozen write-back.
        idle(); do_issue(3);
        settle("waw.pre"); advance();
        idle(); do_issue(3);
        cnt_before = exp_count(1);
        settle("waw.stall");
        check_eq("waw.n.stall_const", 64'(bus_n.stall), 64'd1);
        advance();
        idle(); enable = 1'b0; do_wb(3, 32'h33333333);
        settle("waw.frozen"); advance();
        idle(); set_port(1, 3, 1);
        settle("waw.after");
        check_eq("waw.n.no_write", 64'(bus_n.rd_data[2*WIDTH-1:WIDTH]), 64'd0);
        check_eq("waw.n.count", 64'(bus_n.busy_count), 64'(cnt_before));
        advance();

        // Scenario: reset mid-run while x5 is busy.
        idle(); do_issue(5);
        settle("mid.issue"); advance();
        idle(); set_port(0, 5, 1); issue_valid = 1'b1;
        pulse_reset("mid.reset");
        check_eq("mid.b.x5_zero", 64'(bus_b.rd_data[WIDTH-1:0]), 64'd0);

        // Randomized traffic. Addresses are kept small so that hazards
        // occur often.
        for (int c = 0; c < 400; c++) begin
            idle();
            enable       = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < RP; p++) set_port(p, $urandom_range(0, 7), $urandom_range(0, 1) == 1);
            issue_valid  = $urandom_range(0, 9) < 6;
            issue_has_rd = $urandom_range(0, 3) != 0;
            issue_rd     = AW'($urandom_range(0, 7));
            wb_valid     = $urandom_range(0, 1) == 1;
            wb_rd        = AW'($urandom_range(0, 7));
            wb_data      = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset($sformatf("rnd%0d.reset", c));
            end else begin
                settle($sformatf("rnd%0d", c));
                advance();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
